// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/point/over sequencing, ball motion with wall
// and paddle bounces, paddle positions from ADC pots, and score keeping.
module pong_game_ctrl #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned PAD_H     = 64,
  parameter int unsigned PAD_W     = 8,
  parameter int unsigned BALL_S    = 8,
  parameter int unsigned BALL_V    = 2,
  parameter int unsigned P1_X      = 16,
  parameter int unsigned P2_X      = 616,
  parameter int unsigned WIN_SCORE = 9,
  parameter int unsigned SERVE_FR  = 60,
  parameter int unsigned POINT_FR  = 30
) (
  input  logic       clock_50MHz,
  input  logic       RESET_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       adc_busy,
  input  logic [7:0] adc_p1,
  input  logic [7:0] adc_p2,
  input  logic [1:0] rnd,
  output logic [9:0] x1,
  output logic [9:0] y1,
  output logic [9:0] x2,
  output logic [9:0] y2,
  output logic [9:0] xb,
  output logic [9:0] yb,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over
);

  localparam int unsigned CntMax = (SERVE_FR > POINT_FR) ? SERVE_FR : POINT_FR;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [9:0] CentreX = 10'((H_RES - BALL_S) / 2);
  localparam logic [9:0] CentreY = 10'((V_RES - BALL_S) / 2);
  localparam logic [9:0] LStop   = 10'(P1_X + PAD_W);
  localparam logic [9:0] RStop   = 10'(P2_X - BALL_S);
  localparam logic [9:0] YStop   = 10'(V_RES - BALL_S);
  localparam logic [9:0] XStop   = 10'(H_RES - BALL_S);
  localparam logic [3:0] Win     = 4'(WIN_SCORE);

  localparam logic signed [10:0] VStep = 11'(BALL_V);
  localparam logic signed [10:0] BSide = 11'(BALL_S);
  localparam logic signed [10:0] PadH  = 11'(PAD_H);
  localparam logic signed [10:0] LHit  = 11'(P1_X + PAD_W);
  localparam logic signed [10:0] RHit  = 11'(P2_X);
  localparam logic signed [10:0] YMax  = 11'(V_RES - BALL_S);
  localparam logic signed [10:0] XMax  = 11'(H_RES - BALL_S);

  typedef enum logic [2:0] {StIdle, StServe, StPlay, StPoint, StOver} state_e;

  state_e            state_q, state_d;
  logic [9:0]        xb_q, xb_d, yb_q, yb_d, y1_q, y1_d, y2_q, y2_d;
  logic [3:0]        s1_q, s1_d, s2_q, s2_d;
  logic              go_q, go_d, dx_q, dx_d, dy_q, dy_d, start_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              start_edge, l_hit, r_hit;
  logic signed [10:0] xs, ys, y1s, y2s, nx, ny;

  // Pot value scaled by ~1.625 so the full 8-bit range spans the screen height.
  function automatic logic [9:0] pad_map(input logic [7:0] a);
    pad_map = {2'b00, a} + {3'b000, a[7:1]} + {5'b00000, a[7:3]};
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    sat_inc = (s >= Win) ? Win : s + 4'd1;
  endfunction

  assign start_edge = start & ~start_q;
  assign xs  = $signed({1'b0, xb_q});
  assign ys  = $signed({1'b0, yb_q});
  assign y1s = $signed({1'b0, y1_q});
  assign y2s = $signed({1'b0, y2_q});
  assign nx  = dx_q ? xs + VStep : xs - VStep;
  assign ny  = dy_q ? ys + VStep : ys - VStep;

  // Paddle contact only when the ball crosses the paddle face this frame.
  assign l_hit = !dx_q && (nx <= LHit) && (xs >= LHit) &&
                 (ys + BSide > y1s) && (ys < y1s + PadH);
  assign r_hit = dx_q && (nx + BSide >= RHit) && (xs + BSide <= RHit) &&
                 (ys + BSide > y2s) && (ys < y2s + PadH);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    xb_d    = xb_q;
    yb_d    = yb_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    cnt_d   = cnt_q;
    if (frame_tick && !adc_busy) begin
      y1_d = pad_map(adc_p1);
      y2_d = pad_map(adc_p2);
    end
    unique case (state_q)
      StIdle: begin
        xb_d = CentreX;
        yb_d = CentreY;
        if (start_edge) begin
          s1_d    = '0;
          s2_d    = '0;
          cnt_d   = CntW'(SERVE_FR);
          state_d = StServe;
        end
      end
      StServe: begin
        xb_d = CentreX;
        yb_d = CentreY;
        if (frame_tick) begin
          if (cnt_q <= CntW'(1)) begin
            cnt_d   = '0;
            dx_d    = rnd[0];
            dy_d    = rnd[1];
            state_d = StPlay;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StPlay: begin
        if (frame_tick) begin
          if (ny < 0) begin
            yb_d = '0;
            dy_d = 1'b1;
          end else if (ny > YMax) begin
            yb_d = YStop;
            dy_d = 1'b0;
          end else begin
            yb_d = ny[9:0];
          end
          if (l_hit) begin
            xb_d = LStop;
            dx_d = 1'b1;
          end else if (r_hit) begin
            xb_d = RStop;
            dx_d = 1'b0;
          end else if (nx <= 0) begin
            xb_d    = '0;
            s2_d    = sat_inc(s2_q);
            cnt_d   = CntW'(POINT_FR);
            state_d = StPoint;
          end else if (nx >= XMax) begin
            xb_d    = XStop;
            s1_d    = sat_inc(s1_q);
            cnt_d   = CntW'(POINT_FR);
            state_d = StPoint;
          end else begin
            xb_d = nx[9:0];
          end
        end
      end
      StPoint: begin
        if (frame_tick) begin
          if (cnt_q <= CntW'(1)) begin
            cnt_d = '0;
            if (s1_q == Win || s2_q == Win) begin
              state_d = StOver;
            end else begin
              cnt_d   = CntW'(SERVE_FR);
              xb_d    = CentreX;
              yb_d    = CentreY;
              state_d = StServe;
            end
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StOver: begin
        if (start_edge) begin
          s1_d    = '0;
          s2_d    = '0;
          cnt_d   = CntW'(SERVE_FR);
          xb_d    = CentreX;
          yb_d    = CentreY;
          state_d = StServe;
        end
      end
      default: state_d = StIdle;
    endcase
    go_d = (state_d == StOver);
  end

  // State and output registers.
  always_ff @(posedge clock_50MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= StIdle;
      xb_q    <= CentreX;
      yb_q    <= CentreY;
      y1_q    <= '0;
      y2_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      go_q    <= 1'b0;
      dx_q    <= 1'b0;
      dy_q    <= 1'b0;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xb_q    <= xb_d;
      yb_q    <= yb_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      go_q    <= go_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cnt_q   <= cnt_d;
      start_q <= start;
    end
  end

  assign x1        = 10'(P1_X);
  assign x2        = 10'(P2_X);
  assign y1        = y1_q;
  assign y2        = y2_q;
  assign xb        = xb_q;
  assign yb        = yb_q;
  assign score1    = s1_q;
  assign score2    = s2_q;
  assign game_over = go_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: serve, walls, paddles, misses, game over, reset.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0, start = 1'b0, adc_busy = 1'b0;
  logic [7:0] adc_p1 = 8'd0, adc_p2 = 8'd0;
  logic [1:0] rnd = 2'd0;
  logic [9:0] x1, y1, x2, y2, xb, yb;
  logic [3:0] score1, score2;
  logic       game_over;
  int         total = 0;
  int         passed = 0;

  pong_game_ctrl dut (
    .clock_50MHz(clk), .RESET_n(rst_n), .frame_tick(frame_tick), .start(start),
    .adc_busy(adc_busy), .adc_p1(adc_p1), .adc_p2(adc_p2), .rnd(rnd),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .xb(xb), .yb(yb),
    .score1(score1), .score2(score2), .game_over(game_over)
  );

  always #10 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; adc_busy = 1'b0;
    adc_p1 = 8'd0; adc_p2 = 8'd0; rnd = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (x1 !== 10'd16) $display("FAIL rst_x1: got %0d want 16", x1); else passed++;
    total++; if (x2 !== 10'd616) $display("FAIL rst_x2: got %0d want 616", x2); else passed++;
    total++; if (y1 !== 10'd0) $display("FAIL rst_y1: got %0d want 0", y1); else passed++;
    total++; if (y2 !== 10'd0) $display("FAIL rst_y2: got %0d want 0", y2); else passed++;
    total++; if (xb !== 10'd316) $display("FAIL rst_xb: got %0d want 316", xb); else passed++;
    total++; if (yb !== 10'd236) $display("FAIL rst_yb: got %0d want 236", yb); else passed++;
    total++; if (score1 !== 4'd0) $display("FAIL rst_s1: got %0d want 0", score1); else passed++;
    total++; if (score2 !== 4'd0) $display("FAIL rst_s2: got %0d want 0", score2); else passed++;
    total++; if (game_over !== 1'b0) $display("FAIL rst_go: got %0d want 0", game_over); else passed++;
  endtask

  task automatic test_paddle();
    do_reset();
    adc_p1 = 8'd255; adc_p2 = 8'd240;
    ticks(1);
    total++; if (y1 !== 10'd413) $display("FAIL pad_y1_max: got %0d want 413", y1); else passed++;
    total++; if (y2 !== 10'd390) $display("FAIL pad_y2: got %0d want 390", y2); else passed++;
    adc_busy = 1'b1; adc_p1 = 8'd0;
    ticks(1);
    total++; if (y1 !== 10'd413) $display("FAIL pad_busy_hold: got %0d want 413", y1); else passed++;
    adc_busy = 1'b0;
    ticks(1);
    total++; if (y1 !== 10'd0) $display("FAIL pad_y1_zero: got %0d want 0", y1); else passed++;
  endtask

  task automatic test_serve();
    do_reset();
    rnd = 2'b11;
    pulse_start();
    ticks(59);
    total++; if (xb !== 10'd316) $display("FAIL serve_hold_xb: got %0d want 316", xb); else passed++;
    ticks(1);
    total++; if (yb !== 10'd236) $display("FAIL serve_end_yb: got %0d want 236", yb); else passed++;
    ticks(1);
    total++; if (xb !== 10'd318) $display("FAIL play1_xb: got %0d want 318", xb); else passed++;
    total++; if (yb !== 10'd238) $display("FAIL play1_yb: got %0d want 238", yb); else passed++;
    pulse_start();
    ticks(1);
    total++; if (xb !== 10'd320) $display("FAIL start_in_play_xb: got %0d want 320", xb); else passed++;
    // Asynchronous reset mid-rally, checked before the next rising edge.
    #5 rst_n = 1'b0;
    #1;
    total++; if (xb !== 10'd316) $display("FAIL async_play_xb: got %0d want 316", xb); else passed++;
    total++; if (yb !== 10'd236) $display("FAIL async_play_yb: got %0d want 236", yb); else passed++;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_wall_and_hit();
    do_reset();
    rnd = 2'b00;
    pulse_start();
    ticks(60);
    ticks(117);
    total++; if (yb !== 10'd2 || xb !== 10'd82) $display("FAIL wall_pre: got %0d,%0d want 82,2", xb, yb); else passed++;
    ticks(1);
    total++; if (yb !== 10'd0 || xb !== 10'd80) $display("FAIL wall_top: got %0d,%0d want 80,0", xb, yb); else passed++;
    ticks(1);
    total++; if (yb !== 10'd0 || xb !== 10'd78) $display("FAIL wall_clamp: got %0d,%0d want 78,0", xb, yb); else passed++;
    ticks(1);
    total++; if (yb !== 10'd2 || xb !== 10'd76) $display("FAIL wall_down: got %0d,%0d want 76,2", xb, yb); else passed++;
    ticks(25);
    total++; if (xb !== 10'd26 || yb !== 10'd52) $display("FAIL lhit_pre: got %0d,%0d want 26,52", xb, yb); else passed++;
    ticks(1);
    total++; if (xb !== 10'd24 || yb !== 10'd54) $display("FAIL lhit_stop: got %0d,%0d want 24,54", xb, yb); else passed++;
    ticks(1);
    total++; if (xb !== 10'd26 || yb !== 10'd56) $display("FAIL lhit_right: got %0d,%0d want 26,56", xb, yb); else passed++;
    total++; if (score2 !== 4'd0) $display("FAIL lhit_noscore: got %0d want 0", score2); else passed++;
  endtask

  task automatic test_miss();
    do_reset();
    rnd = 2'b00; adc_p1 = 8'd124;
    pulse_start();
    ticks(60);
    total++; if (y1 !== 10'd201) $display("FAIL miss_y1: got %0d want 201", y1); else passed++;
    ticks(146);
    total++; if (xb !== 10'd24 || yb !== 10'd54) $display("FAIL miss_pass: got %0d,%0d want 24,54", xb, yb); else passed++;
    ticks(11);
    total++; if (xb !== 10'd2 || score2 !== 4'd0) $display("FAIL miss_pre: got x=%0d s2=%0d want x=2 s2=0", xb, score2); else passed++;
    ticks(1);
    total++; if (score2 !== 4'd1 || xb !== 10'd0) $display("FAIL miss_score2: got s2=%0d x=%0d want s2=1 x=0", score2, xb); else passed++;
    total++; if (yb !== 10'd78) $display("FAIL miss_yb: got %0d want 78", yb); else passed++;
    ticks(5);
    total++; if (xb !== 10'd0 || yb !== 10'd78) $display("FAIL point_frozen: got %0d,%0d want 0,78", xb, yb); else passed++;
    #5 rst_n = 1'b0;
    #1;
    total++; if (score2 !== 4'd0) $display("FAIL async_point_s2: got %0d want 0", score2); else passed++;
    total++; if (xb !== 10'd316) $display("FAIL async_point_xb: got %0d want 316", xb); else passed++;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_game_over();
    do_reset();
    rnd = 2'b01; adc_p2 = 8'd124;
    pulse_start();
    for (int r = 1; r <= 9; r++) begin
      ticks(60);
      ticks(158);
      total++; if (score1 !== 4'(r) || xb !== 10'd632)
        $display("FAIL round%0d_s1: got s1=%0d x=%0d want s1=%0d x=632", r, score1, xb, r); else passed++;
      if (r < 9) begin
        ticks(30);
        total++; if (xb !== 10'd316 || game_over !== 1'b0)
          $display("FAIL round%0d_reserve: got x=%0d go=%0d want x=316 go=0", r, xb, game_over); else passed++;
      end
    end
    ticks(29);
    total++; if (game_over !== 1'b0) $display("FAIL over_early: got %0d want 0", game_over); else passed++;
    ticks(1);
    total++; if (game_over !== 1'b1) $display("FAIL over_set: got %0d want 1", game_over); else passed++;
    total++; if (score2 !== 4'd0) $display("FAIL over_s2: got %0d want 0", score2); else passed++;
    ticks(3);
    total++; if (xb !== 10'd632 || game_over !== 1'b1) $display("FAIL over_still: got x=%0d go=%0d want x=632 go=1", xb, game_over); else passed++;
    pulse_start();
    total++; if (score1 !== 4'd0 || game_over !== 1'b0) $display("FAIL restart: got s1=%0d go=%0d want s1=0 go=0", score1, game_over); else passed++;
    total++; if (xb !== 10'd316) $display("FAIL restart_xb: got %0d want 316", xb); else passed++;
    ticks(61);
    total++; if (xb !== 10'd318 || yb !== 10'd234) $display("FAIL restart_play: got %0d,%0d want 318,234", xb, yb); else passed++;
  endtask

  initial begin
    test_reset();
    test_paddle();
    test_serve();
    test_wall_and_hit();
    test_miss();
    test_game_over();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
